// File: rtl/multiplier_21bits.sv
// rtl/multiplier_21bits.sv - sequential signed shift-add multiplier with FRAC scaling and saturation
// Fixed latency WIDTH+1 from acceptance to finish; operands are multiplied as magnitudes.
module multiplier_21bits #(
  parameter int WIDTH = 21,
  parameter int FRAC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             open,
  input  logic [WIDTH-1:0] multiplicand_input,
  input  logic [WIDTH-1:0] multiplier_input,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] product_output,
  output logic             overflow
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [AW-1:0] POS_LIMIT = (AW'(1) << (WIDTH - 1)) - AW'(1);
  localparam logic [AW-1:0] NEG_LIMIT = AW'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_sign;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_product;
  logic             r_overflow;
  logic             r_finish;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_mag;
  logic [WIDTH-1:0] w_mag_lim;
  logic [WIDTH-1:0] w_result;
  logic             w_clamp;
  logic             w_last_iter;

  // The most negative operand maps onto 2^(WIDTH-1), which is still representable unsigned.
  assign w_abs_a = multiplicand_input[WIDTH-1] ? (~multiplicand_input + WIDTH'(1))
                                               : multiplicand_input;
  assign w_abs_b = multiplier_input[WIDTH-1] ? (~multiplier_input + WIDTH'(1))
                                             : multiplier_input;

  assign w_addend    = {{WIDTH{1'b0}}, r_mcand} << r_count;
  assign w_last_iter = (r_count == CW'(WIDTH - 1));
  assign w_mag       = r_acc >> FRAC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (open) w_next_state = S_BUSY;
      S_BUSY: if (w_last_iter) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Negative results may use one extra step of magnitude before clamping.
  always_comb begin
    w_clamp   = 1'b0;
    w_mag_lim = w_mag[WIDTH-1:0];
    w_result  = '0;
    if (!r_sign) begin
      if (w_mag > POS_LIMIT) begin
        w_clamp   = 1'b1;
        w_mag_lim = POS_LIMIT[WIDTH-1:0];
      end
      w_result = w_mag_lim;
    end else begin
      if (w_mag > NEG_LIMIT) begin
        w_clamp   = 1'b1;
        w_mag_lim = NEG_LIMIT[WIDTH-1:0];
      end
      w_result = ~w_mag_lim + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_sign     <= 1'b0;
      r_acc      <= '0;
      r_count    <= '0;
      r_product  <= '0;
      r_overflow <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_finish <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (open) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_sign   <= multiplicand_input[WIDTH-1] ^ multiplier_input[WIDTH-1];
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        S_BUSY: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + w_addend;
          end
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
        end
        S_DONE: begin
          r_product  <= w_result;
          r_overflow <= w_clamp;
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign finish         = r_finish;
  assign product_output = r_product;
  assign overflow       = r_overflow;

endmodule
